// File: rtl/vga_timing_lbox.sv
// vga_timing_lbox: pixel timing and scan-address generator for a 640x360
// letterboxed window inside 640x480@60 Hz VGA timing (800x525 total).
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_pix_stb    one-cycle pixel strobe; all state advances only on it
//   o_hs, o_vs   active-low horizontal / vertical sync
//   o_x, o_y     pixel column / row inside the window
//   o_active     high while a window pixel is being drawn
//   o_addr       frame-buffer address of the current or next window pixel
//   o_line_end   high during the last pixel period of every line
//   o_frame_end  high during the last pixel period of the frame
module vga_timing_lbox #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned WIN_START  = 60,
    parameter int unsigned WIN_LINES  = 360,
    parameter int unsigned ADDR_WIDTH = 18
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pix_stb,
    output logic                  o_hs,
    output logic                  o_vs,
    output logic [9:0]            o_x,
    output logic [8:0]            o_y,
    output logic                  o_active,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_line_end,
    output logic                  o_frame_end
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W      = $clog2(H_TOTAL);
    localparam int unsigned V_W      = $clog2(V_TOTAL);
    localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
    localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
    localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;
    localparam int unsigned WIN_LAST = WIN_START + WIN_LINES - 1;

    logic [H_W-1:0]        r_h;
    logic [V_W-1:0]        r_v;
    logic [ADDR_WIDTH-1:0] r_addr;

    logic w_hact;
    logic w_win;
    logic w_active;
    logic w_line_end;
    logic w_frame_end;

    // Zero-latency decodes of the raster position.
    always_comb begin
        w_hact      = (r_h < H_W'(H_ACTIVE));
        w_win       = (r_v >= V_W'(WIN_START)) && (r_v <= V_W'(WIN_LAST));
        w_active    = w_win && w_hact;
        w_line_end  = (r_h == H_W'(H_TOTAL - 1));
        w_frame_end = w_line_end && (r_v == V_W'(V_TOTAL - 1));
    end

    // Output drive; row offset is truncated to the 9-bit row width.
    always_comb begin
        o_hs        = !((r_h >= H_W'(HS_FIRST)) && (r_h <= H_W'(HS_LAST)));
        o_vs        = !((r_v >= V_W'(VS_FIRST)) && (r_v <= V_W'(VS_LAST)));
        o_x         = w_hact ? 10'(r_h) : 10'd0;
        o_y         = w_win ? 9'(r_v - V_W'(WIN_START)) : 9'd0;
        o_active    = w_active;
        o_addr      = r_addr;
        o_line_end  = w_line_end;
        o_frame_end = w_frame_end;
    end

    // Raster counters and scan address; state moves only on a pixel strobe.
    // The address counts window pixels already drawn, so in blanking it
    // already points at the next window pixel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h    <= '0;
            r_v    <= '0;
            r_addr <= '0;
        end else if (i_pix_stb) begin
            if (w_line_end) begin
                r_h <= '0;
                if (w_frame_end) begin
                    r_v <= '0;
                end else begin
                    r_v <= r_v + V_W'(1);
                end
            end else begin
                r_h <= r_h + H_W'(1);
            end

            if (w_frame_end) begin
                r_addr <= '0;
            end else if (w_active) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_lbox.sv
// Self-checking bench for vga_timing_lbox. One instance uses the real
// 800x525 raster; a second uses a small raster so whole frames fit the run.
module tb_vga_timing_lbox;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, ws, wl;
    } geom_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, stb_a, rst_b, stb_b;

    logic        a_hs, a_vs, a_act, a_le, a_fe;
    logic [9:0]  a_x;
    logic [8:0]  a_y;
    logic [17:0] a_addr;
    logic        b_hs, b_vs, b_act, b_le, b_fe;
    logic [9:0]  b_x;
    logic [8:0]  b_y;
    logic [17:0] b_addr;

    vga_timing_lbox dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_pix_stb(stb_a),
        .o_hs(a_hs), .o_vs(a_vs), .o_x(a_x), .o_y(a_y), .o_active(a_act),
        .o_addr(a_addr), .o_line_end(a_le), .o_frame_end(a_fe)
    );

    vga_timing_lbox #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .WIN_START(2), .WIN_LINES(8), .ADDR_WIDTH(18)
    ) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_pix_stb(stb_b),
        .o_hs(b_hs), .o_vs(b_vs), .o_x(b_x), .o_y(b_y), .o_active(b_act),
        .o_addr(b_addr), .o_line_end(b_le), .o_frame_end(b_fe)
    );

    int n_cmp = 0;
    int n_err = 0;
    geom_t ga, gb;
    longint na, nb;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs after n strobes since reset, from raster arithmetic:
    // position = n mod frame size; address = window pixels passed so far.
    function automatic logic [63:0] model(input geom_t g, input longint n);
        longint ht, vt, f, h, v, full, part, addr;
        logic hs, vs, win, act, le, fe;
        logic [9:0] x;
        logic [8:0] y;
        ht   = g.ha + g.hf + g.hs + g.hb;
        vt   = g.va + g.vf + g.vs + g.vb;
        f    = n % (ht * vt);
        h    = f % ht;
        v    = f / ht;
        hs   = !(h >= g.ha + g.hf && h < g.ha + g.hf + g.hs);
        vs   = !(v >= g.va + g.vf && v < g.va + g.vf + g.vs);
        win  = (v >= g.ws) && (v < g.ws + g.wl);
        act  = win && (h < g.ha);
        x    = (h < g.ha) ? 10'(h) : 10'd0;
        y    = win ? 9'(v - g.ws) : 9'd0;
        le   = (h == ht - 1);
        fe   = le && (v == vt - 1);
        full = v - g.ws;
        if (full < 0) full = 0;
        if (full > g.wl) full = g.wl;
        part = win ? ((h < g.ha) ? h : g.ha) : 0;
        addr = full * g.ha + part;
        return {22'd0, hs, vs, x, y, act, le, fe, 18'(addr)};
    endfunction

    function automatic logic [63:0] obs_a();
        return {22'd0, a_hs, a_vs, a_x, a_y, a_act, a_le, a_fe, a_addr};
    endfunction

    function automatic logic [63:0] obs_b();
        return {22'd0, b_hs, b_vs, b_x, b_y, b_act, b_le, b_fe, b_addr};
    endfunction

    // One clock: drive at negedge, model updates at posedge, sample at next negedge.
    task automatic step(input logic sa, input logic ra, input logic sb, input logic rb);
        stb_a = sa; rst_a = ra; stb_b = sb; rst_b = rb;
        @(posedge clk);
        if (ra) na = 0; else if (sa) na++;
        if (rb) nb = 0; else if (sb) nb++;
        @(negedge clk);
        stb_a = 1'b0; rst_a = 1'b0; stb_b = 1'b0; rst_b = 1'b0;
        check("a_outputs", obs_a(), model(ga, na));
        check("b_outputs", obs_b(), model(gb, nb));
    endtask

    int hs_low, hs_first, vs_low, fe_cnt, hsb_low, gap;
    int unsigned pick;

    initial begin
        ga = '{640, 16, 96, 48, 480, 10, 2, 33, 60, 360};
        gb = '{16, 2, 3, 3, 12, 1, 2, 2, 2, 8};
        na = 0; nb = 0;
        rst_a = 1'b1; rst_b = 1'b1; stb_a = 1'b1; stb_b = 1'b1;
        @(negedge clk);
        step(1'b1, 1'b1, 1'b1, 1'b1);

        // Reset state
        check("rst_hs", 64'(a_hs), 64'd1);
        check("rst_vs", 64'(a_vs), 64'd1);
        check("rst_x", 64'(a_x), 64'd0);
        check("rst_active", 64'(a_act), 64'd0);
        check("rst_line_end", 64'(a_le), 64'd0);
        check("rst_frame_end", 64'(a_fe), 64'd0);
        check("rst_addr", 64'(a_addr), 64'd0);

        // First strobe
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("s1_x", 64'(a_x), 64'd1);
        check("s1_y", 64'(a_y), 64'd0);
        check("s1_active", 64'(a_act), 64'd0);
        check("s1_hs_vs", 64'({a_hs, a_vs}), 64'd3);
        check("s1_addr", 64'(a_addr), 64'd0);

        // Into the window: line 60, h=0
        while (na < 48000) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("win0_active", 64'(a_act), 64'd1);
        check("win0_xy", 64'({a_x, a_y}), 64'd0);
        check("win0_addr", 64'(a_addr), 64'd0);
        repeat (640) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("win0_blank_active", 64'(a_act), 64'd0);
        check("win0_blank_addr", 64'(a_addr), 64'd640);
        check("win0_blank_le", 64'(a_le), 64'd0);

        // HS width and position over line 61
        while (na < 48800) step(1'b1, 1'b0, 1'b0, 1'b0);
        hs_low = 0; hs_first = -1;
        for (int i = 0; i < 800; i++) begin
            if (!a_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = i;
            end
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("hs_low_count", 64'(hs_low), 64'd96);
        check("hs_first_h", 64'(hs_first), 64'd656);

        // Mid-frame reset with no strobe on that edge
        while (na < 70 * 800 + 300) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_rst_y", 64'(a_y), 64'd10);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("mid_rst_xy", 64'({a_x, a_y}), 64'd0);
        check("mid_rst_addr", 64'(a_addr), 64'd0);
        check("mid_rst_sync", 64'({a_hs, a_vs, a_act}), 64'b110);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst_x", 64'(a_x), 64'd1);

        // Small raster: one frame at every-4th-clock spacing
        vs_low = 0; fe_cnt = 0; hsb_low = 0;
        for (int i = 0; i < 408; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (!b_vs) vs_low++;
            if (!b_hs) hsb_low++;
            if (b_fe) fe_cnt++;
            if (nb % 408 == 240) check("b_addr_after_win", 64'(b_addr), 64'd128);
            repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("b_vs_low_frame", 64'(vs_low), 64'd48);
        check("b_hs_low_frame", 64'(hsb_low), 64'd51);
        check("b_fe_frame", 64'(fe_cnt), 64'd1);
        check("b_frame_wrap_addr", 64'(b_addr), 64'd0);

        // Two frames at irregular spacing (1, 4, 7 or random)
        fe_cnt = 0; vs_low = 0;
        for (int i = 0; i < 816; i++) begin
            pick = $urandom_range(0, 3);
            gap = (pick == 0) ? 1 : (pick == 1) ? 4 : (pick == 2) ? 7 : int'($urandom_range(1, 7));
            repeat (gap - 1) step(1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (b_fe) fe_cnt++;
            if (!b_vs) vs_low++;
        end
        check("b_fe_two_frames", 64'(fe_cnt), 64'd2);
        check("b_vs_low_two_frames", 64'(vs_low), 64'd96);

        // Reset wins over a coincident strobe mid-frame
        repeat (150) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("b_rst_with_stb", obs_b(), model(gb, 0));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("b_post_rst_x", 64'(b_x), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
